envelope_mixer: RTL and testbench
=================================

// Module: envelope_mixer
// PURPOSE
//   Per-voice ADSR envelope generator plus voice mixer for the keyboard synth.
//   Sits between the SPI note-sample decode and the DAC output. Takes NVOICES
//   sample streams plus per-voice key gates. Scales each stream by a key-driven
//   envelope (attack/hold/decay/sustain/release) and mixes the results into one
//   DAC sample. Supports retrigger and release on key-up.
// PARAMETERS
//   NVOICES     3       number of voices / channels
//   WAVE_W      8       sample width in and out
//   ENV_W       8       envelope level width; LMAX = 2**ENV_W-1
//   ATTACK_DIV  625000  clk cycles per +1 level step in ATTACK
//   HOLD_CYC    25000000 clk cycles spent at LMAX in HOLD
//   DECAY_DIV   156250  clk cycles per -1 level step in DECAY
//   SUSTAIN_LVL 192     level held in SUSTAIN (must be < LMAX)
//   RELEASE_DIV 600000  clk cycles per -1 level step in RELEASE
//   MIX_MODE    1       0: saturating sum; 1: sum >> $clog2(NVOICES)
// PORTS
//   clk        in   1               system clock
//   reset_n    in   1               synchronous reset, active low
//   key_on     in   NVOICES         per-voice gate, level-sensitive, high = key down
//   wave_in    in   NVOICES*WAVE_W  per-voice unsigned samples; voice i at [i*WAVE_W +: WAVE_W]
//   env_level  out  NVOICES*ENV_W   current envelope level per voice (registered)
//   active     out  NVOICES         1 while voice state != IDLE
//   mix_out    out  WAVE_W          mixed, enveloped sample to DAC (registered)
// BEHAVIOUR
//   Reset (reset_n=0 at posedge): state=IDLE, level=0, div_cnt=0, key_q=0, scaled=0, mix_out=0, active=0.
//     Reset overrides everything, including mid-envelope.
//   key_q (per voice) registers key_on; rise = key_on & ~key_q.
//     A key held through reset release counts as a rise.
//   div_cnt: per-voice, cleared on every state entry. A step fires when div_cnt==DIV-1, then div_cnt wraps to 0.
//     First step therefore occurs DIV cycles after state entry.
//   FSM per voice (transition takes effect next clk):
//     IDLE    : level=0; rise -> ATTACK.
//     ATTACK  : +1 per ATTACK_DIV. Step reaching LMAX -> HOLD. key_on=0 -> RELEASE (takes priority over step).
//     HOLD    : level=LMAX for HOLD_CYC cycles -> DECAY. key_on=0 -> RELEASE.
//     DECAY   : -1 per DECAY_DIV. Step reaching SUSTAIN_LVL -> SUSTAIN. key_on=0 -> RELEASE.
//     SUSTAIN : level=SUSTAIN_LVL; key_on=0 -> RELEASE.
//     RELEASE : -1 per RELEASE_DIV. Step reaching 0 -> IDLE. Rise -> ATTACK from current level (no jump to 0).
//       Level 0 on entry -> IDLE next cycle.
//   Level never wraps: saturates at 0 and LMAX.
//   Scale (stage 1, registered): scaled_i = (wave_i * level_i) >> ENV_W.
//     Full WAVE_W+ENV_W product width; keep the low WAVE_W bits after the shift.
//   Mix (stage 2, registered): sum = sum of scaled_i in WAVE_W+$clog2(NVOICES)+1 bits.
//     MIX_MODE 0: mix_out = min(sum, 2**WAVE_W-1). MIX_MODE 1: mix_out = sum >> $clog2(NVOICES).
//   Latency: wave_in -> mix_out = 2 clk; level change -> mix_out = 2 clk.
//   Voices are fully independent. Simultaneous events on different voices are handled in the same cycle.
// STRUCTURE
//   piano_pkg: typedef enum logic [2:0] env_state_t {IDLE, ATTACK, HOLD, DECAY, SUSTAIN, RELEASE};
//     plus the default timing constants.
//   Sub-module env_voice (one per voice, generate loop): FSM, div_cnt, level, scaled-sample register.
//   Top envelope_mixer: generate loop of env_voice plus the mix adder tree and saturation/shift register.
// TESTING  (NVOICES=3, WAVE_W=8, ENV_W=4, ATTACK_DIV=2, HOLD_CYC=4, DECAY_DIV=3, SUSTAIN_LVL=8, RELEASE_DIV=2)
//   1. reset_n=0 for 2 clk, key_on=3'b111, wave_in all 8'hFF
//      -> env_level=0, active=0, mix_out=0; after release, all voices enter ATTACK next cycle.
//   2. key_on[0] rises and is held, wave_in[0]=8'hFF
//      -> level 15 at 30 clk after ATTACK entry; 15 for 4 clk; 8 after 21 more clk;
//      -> then constant; mix_out settles to (0x7F>>2)=0x1F (MIX_MODE 1).
//   3. key_on[0] drops when level=5 in ATTACK -> RELEASE; level 0 after 10 clk; active[0]=0 next clk.
//   4. key_on[1] drops, then re-rises when level=6 in RELEASE -> ATTACK; next step gives 7 (no reset to 0).
//   5. All voices level=15, wave_in all 8'hFF (scaled=0xEF each, sum=717)
//      -> MIX_MODE 0: mix_out=8'hFF; MIX_MODE 1: mix_out=8'hB3.
//   6. Reset asserted while voice 2 is in SUSTAIN -> next clk level=0, state IDLE, mix_out=0.

Source files
------------

// File: rtl/envelope_mixer_pkg.sv
// Shared types and default timing constants for the per-voice envelope generator and mixer.
package envelope_mixer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ATTACK,
      HOLD,
      DECAY,
      SUSTAIN,
      RELEASE
   } env_state_t;

   localparam int unsigned DEF_ATTACK_DIV  = 625000;
   localparam int unsigned DEF_HOLD_CYC    = 25000000;
   localparam int unsigned DEF_DECAY_DIV   = 156250;
   localparam int unsigned DEF_SUSTAIN_LVL = 192;
   localparam int unsigned DEF_RELEASE_DIV = 600000;

   function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/env_voice.sv
// One voice: key-driven ADSR state machine, step divider, level register and scaled-sample register.
module env_voice
   import envelope_mixer_pkg::*;
#(
   parameter int unsigned WAVE_W      = 8,
   parameter int unsigned ENV_W       = 8,
   parameter int unsigned ATTACK_DIV  = DEF_ATTACK_DIV,
   parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
   parameter int unsigned DECAY_DIV   = DEF_DECAY_DIV,
   parameter int unsigned SUSTAIN_LVL = DEF_SUSTAIN_LVL,
   parameter int unsigned RELEASE_DIV = DEF_RELEASE_DIV
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              key_on,
   input  logic [WAVE_W-1:0] wave,
   output logic [ENV_W-1:0]  level,
   output logic              active,
   output logic [WAVE_W-1:0] scaled
);

   localparam int unsigned CNT_MAX = max_of(max_of(ATTACK_DIV, HOLD_CYC), max_of(DECAY_DIV, RELEASE_DIV));
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned PROD_W  = WAVE_W + ENV_W;

   localparam logic [ENV_W-1:0] LMAX = '1;
   localparam logic [ENV_W-1:0] SUS  = ENV_W'(SUSTAIN_LVL);
   localparam logic [CNT_W-1:0] ATT_LAST  = CNT_W'(ATTACK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] DEC_LAST  = CNT_W'(DECAY_DIV - 1);
   localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_DIV - 1);

   env_state_t        state;
   logic              key_q;
   logic              rise;
   logic [CNT_W-1:0]  div_cnt;
   logic [PROD_W-1:0] prod;

   always_comb begin
      rise   = key_on & ~key_q;
      active = (state != IDLE);
      prod   = PROD_W'(wave) * PROD_W'(level);
   end

   // div_cnt counts by default; every state change and every step clears it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         level   <= '0;
         div_cnt <= '0;
         key_q   <= 1'b0;
         scaled  <= '0;
      end else begin
         key_q   <= key_on;
         scaled  <= WAVE_W'(prod >> ENV_W);
         div_cnt <= div_cnt + 1'b1;
         unique case (state)
            IDLE: begin
               level   <= '0;
               div_cnt <= '0;
               if (rise) state <= ATTACK;
            end
            ATTACK: begin
               if (!key_on) begin
                  state   <= RELEASE;
                  div_cnt <= '0;
               end else if (div_cnt == ATT_LAST) begin
                  div_cnt <= '0;
                  if (level >= LMAX - 1'b1) begin
                     level <= LMAX;
                     state <= HOLD;
                  end else begin
                     level <= level + 1'b1;
                  end
               end
            end
            HOLD: begin
               level <= LMAX;
               if (!key_on) begin
                  state   <= RELEASE;
                  div_cnt <= '0;
               end else if (div_cnt == HOLD_LAST) begin
                  state   <= DECAY;
                  div_cnt <= '0;
               end
            end
            DECAY: begin
               if (!key_on) begin
                  state   <= RELEASE;
                  div_cnt <= '0;
               end else if (div_cnt == DEC_LAST) begin
                  div_cnt <= '0;
                  if (level <= SUS + 1'b1) begin
                     level <= SUS;
                     state <= SUSTAIN;
                  end else begin
                     level <= level - 1'b1;
                  end
               end
            end
            SUSTAIN: begin
               level   <= SUS;
               div_cnt <= '0;
               if (!key_on) state <= RELEASE;
            end
            RELEASE: begin
               if (rise) begin
                  state   <= ATTACK;
                  div_cnt <= '0;
               end else if (level == '0) begin
                  state   <= IDLE;
                  div_cnt <= '0;
               end else if (div_cnt == REL_LAST) begin
                  div_cnt <= '0;
                  level   <= level - 1'b1;
                  if (level == ENV_W'(1)) state <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               level   <= '0;
               div_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/envelope_mixer.sv
// Top: one env_voice per channel, then a registered sum with saturation or averaging shift.
module envelope_mixer
   import envelope_mixer_pkg::*;
#(
   parameter int unsigned NVOICES     = 3,
   parameter int unsigned WAVE_W      = 8,
   parameter int unsigned ENV_W       = 8,
   parameter int unsigned ATTACK_DIV  = DEF_ATTACK_DIV,
   parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
   parameter int unsigned DECAY_DIV   = DEF_DECAY_DIV,
   parameter int unsigned SUSTAIN_LVL = DEF_SUSTAIN_LVL,
   parameter int unsigned RELEASE_DIV = DEF_RELEASE_DIV,
   parameter int unsigned MIX_MODE    = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NVOICES-1:0]        key_on,
   input  logic [NVOICES*WAVE_W-1:0] wave_in,
   output logic [NVOICES*ENV_W-1:0]  env_level,
   output logic [NVOICES-1:0]        active,
   output logic [WAVE_W-1:0]         mix_out
);

   localparam int unsigned SHIFT = $clog2(NVOICES);
   localparam int unsigned SUM_W = WAVE_W + SHIFT + 1;

   logic [WAVE_W-1:0] scaled [NVOICES];
   logic [SUM_W-1:0]  sum;
   logic [WAVE_W-1:0] mix_next;

   for (genvar v = 0; v < NVOICES; v++) begin : g_voice
      env_voice #(
         .WAVE_W      (WAVE_W),
         .ENV_W       (ENV_W),
         .ATTACK_DIV  (ATTACK_DIV),
         .HOLD_CYC    (HOLD_CYC),
         .DECAY_DIV   (DECAY_DIV),
         .SUSTAIN_LVL (SUSTAIN_LVL),
         .RELEASE_DIV (RELEASE_DIV)
      ) u_voice (
         .clk     (clk),
         .reset_n (reset_n),
         .key_on  (key_on[v]),
         .wave    (wave_in[v*WAVE_W +: WAVE_W]),
         .level   (env_level[v*ENV_W +: ENV_W]),
         .active  (active[v]),
         .scaled  (scaled[v])
      );
   end

   always_comb begin
      sum = '0;
      for (int unsigned i = 0; i < NVOICES; i++) sum = sum + SUM_W'(scaled[i]);
      if (MIX_MODE == 0)
         mix_next = (sum > SUM_W'({WAVE_W{1'b1}})) ? '1 : WAVE_W'(sum);
      else
         mix_next = WAVE_W'(sum >> SHIFT);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) mix_out <= '0;
      else          mix_out <= mix_next;
   end

endmodule

// File: tb/tb_envelope_mixer.sv
// Scenario bench for envelope_mixer: two instances (averaging and saturating mix) share stimulus.
module tb_envelope_mixer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  key_on;
   logic [23:0] wave_in;
   logic [11:0] lvl1, lvl0;
   logic [2:0]  act1, act0;
   logic [7:0]  mix1, mix0;

   int checks = 0;
   int errors = 0;

   typedef struct { int lvl; int mix; } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   envelope_mixer #(.NVOICES(3), .WAVE_W(8), .ENV_W(4), .ATTACK_DIV(2), .HOLD_CYC(4),
                    .DECAY_DIV(3), .SUSTAIN_LVL(8), .RELEASE_DIV(2), .MIX_MODE(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .key_on(key_on), .wave_in(wave_in),
      .env_level(lvl1), .active(act1), .mix_out(mix1));

   envelope_mixer #(.NVOICES(3), .WAVE_W(8), .ENV_W(4), .ATTACK_DIV(2), .HOLD_CYC(4),
                    .DECAY_DIV(3), .SUSTAIN_LVL(8), .RELEASE_DIV(2), .MIX_MODE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .key_on(key_on), .wave_in(wave_in),
      .env_level(lvl0), .active(act0), .mix_out(mix0));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [2:0] keys);
      reset_n = 1'b0;
      key_on  = keys;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Expected voice level k cycles after ATTACK entry with the key held.
   function automatic int adsr_level(input int k);
      if (k < 0)  return 0;
      if (k <= 30) return k / 2;
      if (k <= 33) return 15;
      if (k <= 55) return 15 - (k - 34) / 3;
      return 8;
   endfunction

   // Single full-scale voice at level l through scale and the >>2 mix.
   function automatic int mix_one(input int l);
      return ((255 * l) >> 4) >> 2;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      key_on  = 3'b111;
      wave_in = 24'hFFFFFF;
      tick();
      tick();
      checks++; if (lvl1 !== 12'h000) begin errors++; $display("FAIL reset_level got %h want 000", lvl1); end
      checks++; if (act1 !== 3'b000) begin errors++; $display("FAIL reset_active got %b want 000", act1); end
      checks++; if (mix1 !== 8'h00 || mix0 !== 8'h00) begin errors++; $display("FAIL reset_mix got %h/%h want 00/00", mix1, mix0); end
      reset_n = 1'b1;
      tick();
      checks++; if (act1 !== 3'b111) begin errors++; $display("FAIL held_key_attack got %b want 111", act1); end
      checks++; if (lvl1 !== 12'h000) begin errors++; $display("FAIL attack_entry_level got %h want 000", lvl1); end
      tick();
      tick();
      checks++; if (lvl1 !== 12'h111) begin errors++; $display("FAIL first_attack_step got %h want 111", lvl1); end
   endtask

   task automatic test_envelope();
      exp_t e;
      logic [3:0] el;
      logic [7:0] em;
      do_reset(3'b000);
      wave_in = 24'h0000FF;
      key_on  = 3'b001;
      tick();
      for (int k = 1; k <= 70; k++) begin
         e.lvl = adsr_level(k);
         e.mix = mix_one(adsr_level(k - 2));
         sb.push_back(e);
      end
      for (int k = 1; k <= 70; k++) begin
         tick();
         e  = sb.pop_front();
         el = e.lvl[3:0];
         em = e.mix[7:0];
         checks++; if (lvl1[3:0] !== el) begin errors++; $display("FAIL adsr_level k=%0d got %0d want %0d", k, lvl1[3:0], el); end
         checks++; if (mix1 !== em) begin errors++; $display("FAIL adsr_mix k=%0d got %h want %h", k, mix1, em); end
      end
      checks++; if (mix1 !== 8'h1F) begin errors++; $display("FAIL sustain_mix1 got %h want 1f", mix1); end
      checks++; if (mix0 !== 8'h7F) begin errors++; $display("FAIL sustain_mix0 got %h want 7f", mix0); end
      checks++; if (act1 !== 3'b001 || lvl1[11:4] !== 8'h00) begin errors++; $display("FAIL other_voices_idle got %b/%h want 001/00", act1, lvl1[11:4]); end
   endtask

   task automatic test_release();
      exp_t e;
      logic [3:0] el;
      do_reset(3'b000);
      wave_in = 24'h0000FF;
      key_on  = 3'b001;
      tick();
      repeat (10) tick();
      checks++; if (lvl1[3:0] !== 4'd5) begin errors++; $display("FAIL release_start got %0d want 5", lvl1[3:0]); end
      key_on = 3'b000;
      tick();
      checks++; if (lvl1[3:0] !== 4'd5 || act1[0] !== 1'b1) begin errors++; $display("FAIL release_entry got %0d/%b want 5/1", lvl1[3:0], act1[0]); end
      for (int j = 1; j <= 10; j++) begin
         e.lvl = 5 - j / 2;
         e.mix = 0;
         sb.push_back(e);
      end
      for (int j = 1; j <= 10; j++) begin
         tick();
         e  = sb.pop_front();
         el = e.lvl[3:0];
         checks++; if (lvl1[3:0] !== el) begin errors++; $display("FAIL release_level j=%0d got %0d want %0d", j, lvl1[3:0], el); end
      end
      tick();
      checks++; if (act1[0] !== 1'b0 || lvl1[3:0] !== 4'd0) begin errors++; $display("FAIL release_idle got %b/%0d want 0/0", act1[0], lvl1[3:0]); end
   endtask

   task automatic test_retrigger();
      do_reset(3'b000);
      wave_in = 24'h000000;
      key_on  = 3'b010;
      tick();
      repeat (12) tick();
      checks++; if (lvl1[7:4] !== 4'd6) begin errors++; $display("FAIL retrig_pre got %0d want 6", lvl1[7:4]); end
      key_on = 3'b000;
      tick();
      checks++; if (lvl1[7:4] !== 4'd6 || act1[1] !== 1'b1) begin errors++; $display("FAIL retrig_release got %0d/%b want 6/1", lvl1[7:4], act1[1]); end
      key_on = 3'b010;
      tick();
      checks++; if (lvl1[7:4] !== 4'd6) begin errors++; $display("FAIL retrig_entry got %0d want 6", lvl1[7:4]); end
      tick();
      checks++; if (lvl1[7:4] !== 4'd6) begin errors++; $display("FAIL retrig_wait got %0d want 6", lvl1[7:4]); end
      tick();
      checks++; if (lvl1[7:4] !== 4'd7) begin errors++; $display("FAIL retrig_step got %0d want 7", lvl1[7:4]); end
   endtask

   task automatic test_mix();
      do_reset(3'b000);
      wave_in = 24'hFFFFFF;
      key_on  = 3'b111;
      tick();
      repeat (12) tick();
      checks++; if (mix1 !== 8'h3B) begin errors++; $display("FAIL mix_avg_l5 got %h want 3b", mix1); end
      checks++; if (mix0 !== 8'hED) begin errors++; $display("FAIL mix_sat_l5 got %h want ed", mix0); end
      repeat (20) tick();
      checks++; if (lvl1 !== 12'hFFF) begin errors++; $display("FAIL mix_levels got %h want fff", lvl1); end
      checks++; if (mix1 !== 8'hB3) begin errors++; $display("FAIL mix_avg_full got %h want b3", mix1); end
      checks++; if (mix0 !== 8'hFF) begin errors++; $display("FAIL mix_sat_full got %h want ff", mix0); end
   endtask

   task automatic test_reset_mid();
      do_reset(3'b000);
      wave_in = 24'hFF0000;
      key_on  = 3'b100;
      tick();
      repeat (60) tick();
      checks++; if (lvl1[11:8] !== 4'd8 || mix1 !== 8'h1F) begin errors++; $display("FAIL sustain_v2 got %0d/%h want 8/1f", lvl1[11:8], mix1); end
      reset_n = 1'b0;
      tick();
      checks++; if (lvl1 !== 12'h000 || act1 !== 3'b000) begin errors++; $display("FAIL midreset_state got %h/%b want 000/000", lvl1, act1); end
      checks++; if (mix1 !== 8'h00 || mix0 !== 8'h00) begin errors++; $display("FAIL midreset_mix got %h/%h want 00/00", mix1, mix0); end
      reset_n = 1'b1;
      key_on  = 3'b000;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_envelope();
      test_release();
      test_retrigger();
      test_mix();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
